// File: rtl/acq_pkg.sv
// Shared types and default widths for the triggered acquisition window.
package acq_pkg;

    localparam int ACQ_DATA_WIDTH = 16;
    localparam int ACQ_LEN_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } acq_state_t;

endpackage

// File: rtl/acq_fifo.sv
// Synchronous {data,last} FIFO with in-place tlast marking of the newest entry.
// Head is visible the edge after a push into an empty FIFO; push only when !full or popping.
module acq_fifo
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = ACQ_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_push_vld,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    input  logic                  i_mark_last,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_head_dat,
    output logic                  o_head_last
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem_dat [DEPTH];
    logic [DEPTH-1:0]      r_mem_last;
    logic [AW-1:0]         w_wr_idx;
    logic [AW-1:0]         w_rd_idx;
    logic [AW-1:0]         w_newest_idx;

    assign w_wr_idx     = r_wr_ptr[AW-1:0];
    assign w_rd_idx     = r_rd_ptr[AW-1:0];
    assign w_newest_idx = w_wr_idx - AW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push_vld) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Mark only ever targets the newest entry; with DEPTH >= 2 and FIFO full that is never the head.
    always_ff @(posedge clk) begin
        if (i_push_vld) begin
            r_mem_dat[w_wr_idx]  <= i_push_dat;
            r_mem_last[w_wr_idx] <= i_push_last;
        end else if (i_mark_last) begin
            r_mem_last[w_newest_idx] <= 1'b1;
        end
    end

    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign o_head_dat  = o_empty ? '0 : r_mem_dat[w_rd_idx];
    assign o_head_last = !o_empty && r_mem_last[w_rd_idx];

endmodule

// File: rtl/acq_window.sv
// Captures win_len ADC samples after a trigger rising edge and streams them out over AXI-Stream.
// Latency 1 edge from push to head; on a full FIFO samples drop (overflow) and tlast moves to the newest entry.
module acq_window
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH = ACQ_DATA_WIDTH,
    parameter int LEN_WIDTH  = ACQ_LEN_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  trigger_in,
    input  logic [LEN_WIDTH-1:0]  win_len,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  overflow
);

    acq_state_t            r_state;
    acq_state_t            w_next_state;
    logic                  r_trig_d;
    logic                  r_armed;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_overflow;

    logic                  w_trig;
    logic                  w_start;
    logic                  w_cap;
    logic                  w_final;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_push;
    logic                  w_mark;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head_dat;
    logic                  w_head_last;

    // r_armed blocks a trigger_in that was already high when reset released from looking like an edge.
    assign w_trig  = r_armed && trigger_in && !r_trig_d;
    assign w_start = (r_state == ST_IDLE) && w_trig && (win_len != '0);
    assign w_cap   = (r_state == ST_CAPTURE) && adc_valid;
    assign w_final = w_cap && (r_remaining == LEN_WIDTH'(1));
    assign w_pop   = !w_empty && m_axis_tready;
    assign w_room  = !w_full || w_pop;
    assign w_push  = w_cap && w_room;
    assign w_mark  = w_final && !w_room;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_next_state = ST_CAPTURE;
            ST_CAPTURE: if (w_final) w_next_state = ST_DRAIN;
            ST_DRAIN:   if (w_empty) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        case (r_state)
            ST_CAPTURE, ST_DRAIN: busy = 1'b1;
            default:              busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_trig_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_trig_d <= trigger_in;
            r_armed  <= 1'b1;
            if (w_start) begin
                r_remaining <= win_len;
                r_overflow  <= 1'b0;
            end else if (w_cap) begin
                r_remaining <= r_remaining - LEN_WIDTH'(1);
                if (!w_room) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    acq_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push_vld  (w_push),
        .i_push_dat  (adc_data),
        .i_push_last (w_final),
        .i_pop       (w_pop),
        .i_mark_last (w_mark),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_dat  (w_head_dat),
        .o_head_last (w_head_last)
    );

    assign m_axis_tdata  = w_head_dat;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tlast  = w_head_last;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_acq_window.sv
// Bench for acq_window: directed windows plus random traffic against a queue-based reference model.
module tb_acq_window;

    localparam int DW    = 16;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          trigger_in = 1'b0;
    logic [LW-1:0] win_len = '0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          busy;
    logic          overflow;

    acq_window #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .trigger_in    (trigger_in),
        .win_len       (win_len),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } ent_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   beats = 0;
    int   lasts = 0;

    ent_t mq[$];
    int   m_mode;   // 0 idle, 1 capturing, 2 draining
    int   m_rem;
    bit   m_ovf;
    bit   m_armed;
    bit   m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode  = 0;
        m_rem   = 0;
        m_ovf   = 1'b0;
        m_armed = 1'b0;
        m_prev  = 1'b0;
    endtask

    // Applies one rising edge of the window rules to the model, using the inputs present at that edge.
    task automatic model_step();
        bit   pop;
        bit   trig;
        bit   room;
        bit   fin;
        bit   pre_empty;
        ent_t e;
        if (!resetn) begin
            model_reset();
            return;
        end
        pre_empty = (mq.size() == 0);
        pop       = !pre_empty && m_axis_tready;
        trig      = m_armed && trigger_in && !m_prev;
        room      = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (m_mode == 0) begin
            if (trig && win_len != 0) begin
                m_mode = 1;
                m_rem  = int'(win_len);
                m_ovf  = 1'b0;
            end
        end else if (m_mode == 1) begin
            if (adc_valid) begin
                fin = (m_rem == 1);
                if (room) begin
                    e.d = adc_data;
                    e.l = fin;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (fin) begin
                        e   = mq[mq.size()-1];
                        e.l = 1'b1;
                        mq[mq.size()-1] = e;
                    end
                end
                m_rem--;
                if (m_rem == 0) m_mode = 2;
            end
        end else begin
            if (pre_empty) m_mode = 0;
        end
        m_armed = 1'b1;
        m_prev  = trigger_in;
    endtask

    task automatic check_outputs();
        chk("tvalid", m_axis_tvalid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("tdata", m_axis_tdata, mq[0].d);
            chk("tlast", m_axis_tlast, mq[0].l);
        end else begin
            chk("tdata_idle", m_axis_tdata, 0);
            chk("tlast_idle", m_axis_tlast, 0);
        end
        chk("busy", busy, m_mode != 0);
        chk("overflow", overflow, m_ovf);
    endtask

    // One clock: drive inputs, take the edge, step the model, compare and track handshakes.
    task automatic cyc(input bit trig, input int len, input bit av, input bit rdy);
        bit            pv;
        bit            pl;
        bit            stall;
        logic [DW-1:0] pd;
        trigger_in    = trig;
        win_len       = LW'(len);
        adc_valid     = av;
        adc_data      = DW'($urandom);
        m_axis_tready = rdy;
        pv    = m_axis_tvalid;
        pl    = m_axis_tlast;
        pd    = m_axis_tdata;
        stall = pv && !rdy && resetn;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (pv && rdy && resetn) begin
            beats++;
            if (pl) lasts++;
        end
        if (stall && resetn) begin
            chk("stable_vld", m_axis_tvalid, 1);
            chk("stable_dat", m_axis_tdata, pd);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1, 1'b1);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(3);

        // Basic window of 4 with no backpressure.
        beats = 0; lasts = 0;
        cyc(1'b1, 4, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        chk("s1_beats", beats, 4);
        chk("s1_lasts", lasts, 1);
        chk("s1_busy", busy, 0);

        // Full stall for a window of 8: only the first 4 samples survive.
        beats = 0; lasts = 0;
        cyc(1'b1, 8, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        chk("s2_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        chk("s2_beats", beats, 4);
        chk("s2_lasts", lasts, 1);
        idle(2);

        // Zero-length trigger, then a retrigger attempt inside a window of 6.
        beats = 0; lasts = 0;
        cyc(1'b1, 0, 1'b1, 1'b1);
        idle(3);
        chk("s3_zero_busy", busy, 0);
        chk("s3_zero_beats", beats, 0);
        cyc(1'b1, 6, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b1);
        cyc(1'b1, 3, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        chk("s3_beats", beats, 6);
        chk("s3_lasts", lasts, 1);

        // Sparse samples: every third cycle, window of 3.
        beats = 0; lasts = 0;
        cyc(1'b1, 3, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 0, (i % 3) == 2, 1'b1);
        chk("s4_beats", beats, 3);
        chk("s4_lasts", lasts, 1);
        chk("s4_ovf", overflow, 0);

        // Alternating tready, window of 5.
        beats = 0; lasts = 0;
        cyc(1'b1, 5, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 0, 1'b1, (i % 2) == 0);
        chk("s6_beats", beats, 5);
        chk("s6_lasts", lasts, 1);
        chk("s6_ovf", overflow, 0);
        idle(2);

        // Maximum length is latched without truncation; abort with reset.
        cyc(1'b1, 16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        chk("max_busy", busy, 1);
        resetn = 1'b0;
        cyc(1'b0, 0, 1'b0, 1'b1);
        resetn = 1'b1;
        idle(2);

        // Reset after beat 2 of a window of 10, with trigger held high across release.
        beats = 0; lasts = 0;
        cyc(1'b1, 10, 1'b1, 1'b1);
        for (int i = 0; i < 20 && beats < 2; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        chk("s5_two_beats", beats, 2);
        #2;
        resetn = 1'b0;
        #1;
        chk("s5_rst_tvalid", m_axis_tvalid, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_ovf", overflow, 0);
        chk("s5_rst_tdata", m_axis_tdata, 0);
        model_reset();
        @(posedge clk);
        #1;
        cyc(1'b1, 5, 1'b1, 1'b1);
        cyc(1'b1, 5, 1'b1, 1'b1);
        resetn = 1'b1;
        beats = 0; lasts = 0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 5, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        chk("s5_no_beats", beats, 0);
        chk("s5_idle", busy, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 10) == 0, int'($urandom % 10), ($urandom % 4) != 0, ($urandom % 3) != 0);
        end
        idle(30);
        chk("end_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acq_window.md
ACQ_WINDOW -- requirements
Module: acq_window

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the ADC sample width in bits.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16, meaning the width of the window length input.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer entries (power of two, >=2).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port trigger_in, input, 1, meaning the trigger pulse from the upstream delay stage's signal_out.
REQ-007 The block SHALL have port win_len, input, LEN_WIDTH, meaning the number of samples per window, sampled at the trigger.
REQ-008 The block SHALL have port adc_data, input, DATA_WIDTH, meaning the ADC sample.
REQ-009 The block SHALL have port adc_valid, input, 1, meaning the sample strobe; adc_data is valid when it is high.
REQ-010 The block SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), meaning the AXI-Stream sample output.
REQ-011 The block SHALL have port busy, output, 1, meaning the block is in CAPTURE or DRAIN.
REQ-012 The block SHALL have port overflow, output, 1, meaning the sticky flag that one or more samples were dropped in the current or last window.

Function
REQ-013 The block SHALL detect a trigger as a rising edge of trigger_in: trigger_in high at an edge and low at the previous edge.
REQ-014 The state machine SHALL have three states: IDLE, CAPTURE and DRAIN.
REQ-015 IDLE -> CAPTURE SHALL occur on a trigger with win_len != 0, latching remaining = win_len and clearing overflow.
REQ-016 A trigger with win_len == 0 SHALL be ignored, with no state change and overflow unchanged.
REQ-017 Triggers in CAPTURE or DRAIN SHALL be ignored, with no retrigger and no length reload.
REQ-018 In CAPTURE, the first sample eligible for capture SHALL be the adc_valid sample at the edge after the trigger edge.
REQ-019 In CAPTURE, each adc_valid cycle SHALL decrement remaining by 1 and push {adc_data, last} into the FIFO, where last = (remaining == 1).
REQ-020 If the FIFO is full, a non-final sample SHALL be dropped, still decrementing remaining, and overflow SHALL be set.
REQ-021 If the FIFO is full and the sample is the final one, its data SHALL be dropped, the tlast bit of the newest FIFO entry SHALL be set, and overflow SHALL be set; the head entry is never modified, so AXI stability holds.
REQ-022 CAPTURE -> DRAIN SHALL occur when remaining goes from 1 to 0.
REQ-023 DRAIN -> IDLE SHALL occur on the edge after the FIFO becomes empty.
REQ-024 A sample pushed at edge N SHALL be presented on m_axis at edge N+1 if the FIFO was empty, a latency of 1.
REQ-025 The FIFO SHALL pop on tvalid && tready; tdata, tlast and tvalid SHALL be held stable while tvalid && !tready.
REQ-026 A simultaneous push and pop when full SHALL be accepted without drop.
REQ-027 Exactly one tlast SHALL be emitted per window, always on the window's final emitted beat.
REQ-028 The internal remaining counter SHALL be LEN_WIDTH wide with no wrap; win_len = 2^LEN_WIDTH-1 SHALL be legal.

Reset
REQ-029 When resetn is low, the block SHALL immediately (asynchronously) set state IDLE, empty the FIFO, and drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, overflow=0, and clear the trigger edge register.
REQ-030 A reset mid-window SHALL abort the window, and the partial window SHALL NOT be completed after reset release.
REQ-031 A trigger_in held high across reset release SHALL NOT be treated as an edge.

Structure
REQ-032 The FSM state enum and the default DATA_WIDTH/LEN_WIDTH constants SHALL live in the shared package acq_pkg.
REQ-033 The buffer SHALL be a sub-module acq_fifo, a synchronous FIFO with a {data,last} entry, full/empty flags, and a mark_last input that sets tlast of the newest entry.
REQ-034 acq_window SHALL instantiate acq_fifo once and contain the edge detect, FSM, counter and overflow logic.

Verification
REQ-035 A bench SHALL cover: win_len=4, adc_valid always high, tready=1, trigger pulse -> 4 beats on edges T+2..T+5 carrying samples T+1..T+4, tlast on beat 4 only, busy low at T+6.
REQ-036 A bench SHALL cover: win_len=8, tready=0 for the whole window, FIFO_DEPTH=4 -> overflow=1, then with tready=1 exactly 4 beats are emitted with tlast on beat 4 and data = samples 1,2,3,4.
REQ-037 A bench SHALL cover: win_len=0 trigger -> busy stays 0, no beats; a second trigger during a win_len=6 window -> exactly 6 beats, one tlast.
REQ-038 A bench SHALL cover: adc_valid high every third cycle, win_len=3 -> 3 beats, window spans 9 cycles, overflow=0.
REQ-039 A bench SHALL cover: resetn asserted after beat 2 of a win_len=10 window -> tvalid, busy and overflow drop immediately; no beats after release until a new trigger.
REQ-040 A bench SHALL cover: tready toggling 1/0 each cycle, win_len=5 -> 5 beats in order, tdata and tvalid stable on stalled cycles, overflow=0.
